// File: rtl/bmp_word_unpacker_if.sv
// Bus bundle between a 32-bit image FIFO, the word unpacker and the pixel consumer.
// master: the unpacker side; slave: the surrounding system (FIFO, sink, controller).
interface bmp_word_unpacker_if #(
   parameter int unsigned FIFO_WIDTH = 32
);
   logic                  start;
   logic                  fifo_empty;
   logic [FIFO_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic [23:0]           pix_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic                  pix_last;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, fifo_empty, fifo_dout, pix_ready,
      output fifo_rd_en, pix_data, pix_valid, pix_last, busy, done
   );

   modport slave (
      output start, fifo_empty, fifo_dout, pix_ready,
      input  fifo_rd_en, pix_data, pix_valid, pix_last, busy, done
   );
endinterface

// File: rtl/bmp_word_unpacker.sv
// Pops little-endian packed BMP bytes from a 32-bit FWFT FIFO and re-slices them into
// 24-bit BGR pixels (3 words -> 4 pixels), counting pixels and dropping final-word padding.
module bmp_word_unpacker #(
   parameter int unsigned NUM_PIXELS = 388800,
   parameter int unsigned FIFO_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   bmp_word_unpacker_if.master     bus
);

   localparam int unsigned WORDS = (3 * NUM_PIXELS + 3) / 4;
   localparam int unsigned WCW   = $clog2(WORDS + 1);
   localparam int unsigned PCW   = $clog2(NUM_PIXELS + 1);
   localparam logic [WCW-1:0] WordsMax = WCW'(WORDS);
   localparam logic [PCW-1:0] LastPix  = PCW'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [47:0]     buf_q, buf_d;     // byte 0 (oldest) in [7:0]
   logic [2:0]      cnt_q, cnt_d;     // valid bytes in buf_q, 0..6
   logic [WCW-1:0]  words_q;
   logic [PCW-1:0]  pix_q;
   logic            done_q;

   logic [FIFO_WIDTH-1:0] word;
   logic                  run, pix_valid, emit, rd_en, pix_last;
   logic [2:0]            surv;       // bytes surviving this cycle's emit

   assign word = bus.fifo_dout;

   // Pop/emit decisions and the next buffer image; a popped word lands right after survivors.
   always_comb begin
      run       = (state_q == StRun);
      pix_valid = run && (cnt_q >= 3'd3);
      emit      = pix_valid && bus.pix_ready;
      surv      = emit ? cnt_q - 3'd3 : cnt_q;
      rd_en     = run && !bus.fifo_empty && (words_q < WordsMax) && (surv <= 3'd2);
      pix_last  = pix_valid && (pix_q == LastPix);
      cnt_d     = surv + (rd_en ? 3'd4 : 3'd0);
      buf_d     = emit ? {24'd0, buf_q[47:24]} : buf_q;
      if (rd_en) begin
         buf_d = buf_d | (48'(word) << {surv, 3'b000});
      end
   end

   // Frame FSM with buffer, counters and the registered done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         buf_q   <= '0;
         cnt_q   <= '0;
         words_q <= '0;
         pix_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StRun;
                  buf_q   <= '0;
                  cnt_q   <= '0;
                  words_q <= '0;
                  pix_q   <= '0;
               end
            end
            StRun: begin
               buf_q <= buf_d;
               cnt_q <= cnt_d;
               if (rd_en) begin
                  words_q <= words_q + WCW'(1);
               end
               if (emit) begin
                  pix_q <= pix_q + PCW'(1);
               end
               // Leftover padding bytes are dropped with the last pixel.
               if (emit && pix_last) begin
                  state_q <= StDone;
                  buf_q   <= '0;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.pix_valid  = pix_valid;
   assign bus.pix_data   = pix_valid ? buf_q[23:0] : 24'd0;
   assign bus.pix_last   = pix_last;
   assign bus.busy       = run;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_bmp_word_unpacker.sv
// Self-checking bench: a byte-stream model (bytes in, 3-byte pixels out) and FIFO queue,
// directed scenarios (gearbox, backpressure, starvation, reset) plus random frames.
module tb_bmp_word_unpacker;

   localparam int N = 7;                 // 21 bytes -> 6 words, 3 padding bytes
   localparam int W = (3 * N + 3) / 4;

   logic clk = 1'b0;
   logic reset = 1'b0;

   bmp_word_unpacker_if #(.FIFO_WIDTH(32)) bus ();

   bmp_word_unpacker #(.NUM_PIXELS(N), .FIFO_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] fq[$];
   logic [23:0] exp_pix[N];
   logic [23:0] got[N];
   logic [31:0] basic[W];
   logic [31:0] rnd[W];

   // Model: frame active flag, bytes held, words popped, pixels emitted.
   bit running, done_m;
   int avail, popped, idx;
   int dut_pops, last_cnt, mode, bp_cnt, gap_cnt, stall;
   bit seen_valid;
   int t_start, t_first_rd, t_first_valid, t_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic load_frame(input logic [31:0] w[W]);
      logic [31:0] tmp;
      logic [7:0]  b[3];
      fq.delete();
      for (int i = 0; i < W; i++) fq.push_back(w[i]);
      for (int p = 0; p < N; p++) begin
         for (int j = 0; j < 3; j++) begin
            tmp  = w[(3 * p + j) / 4];
            b[j] = tmp[8 * ((3 * p + j) % 4) +: 8];
         end
         exp_pix[p] = {b[2], b[1], b[0]};
         got[p]     = 24'd0;
      end
   endtask

   task automatic step(input logic start_v);
      logic rdy, gap, exp_valid, emit, exp_rd, idle;
      @(negedge clk);
      rdy = 1'b1;
      gap = 1'b0;
      case (mode)
         1: if (running && idx == 1 && bp_cnt < 5) begin rdy = 1'b0; bp_cnt++; end
         2: if (running && dut_pops == 2 && gap_cnt < 10) begin gap = 1'b1; gap_cnt++; end
         3: begin
            rdy = ($urandom_range(9) < 7);
            gap = ($urandom_range(9) < 2);
         end
         default: ;
      endcase
      bus.start      = start_v;
      bus.pix_ready  = rdy;
      bus.fifo_empty = gap || (fq.size() == 0);
      bus.fifo_dout  = bus.fifo_empty ? $urandom : fq[0];
      #1;
      exp_valid = running && (avail >= 3);
      emit      = exp_valid && rdy;
      exp_rd    = running && !bus.fifo_empty && (popped < W) && ((avail - (emit ? 3 : 0)) <= 2);
      chk("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
      chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
      chk("busy", 32'(bus.busy), 32'(running));
      chk("done", 32'(bus.done), 32'(done_m));
      if (exp_valid && idx < N) begin
         chk("pix_data", 32'(bus.pix_data), 32'(exp_pix[idx]));
         chk("pix_last", 32'(bus.pix_last), 32'(idx == N - 1));
      end else begin
         chk("pix_last_idle", 32'(bus.pix_last), 32'd0);
      end
      // Bookkeeping for the edge that follows.
      if (bus.fifo_rd_en && fq.size() > 0) begin
         void'(fq.pop_front());
         dut_pops++;
         if (t_first_rd < 0) t_first_rd = cyc;
      end
      if (bus.pix_valid) begin
         seen_valid = 1'b1;
         if (t_first_valid < 0) t_first_valid = cyc;
      end else if (bus.busy && seen_valid) begin
         stall++;
      end
      idle = !running && !done_m;
      done_m = 1'b0;
      if (exp_rd) begin
         popped++;
         avail += 4;
      end
      if (emit) begin
         if (idx < N) got[idx] = bus.pix_data;
         if (bus.pix_last) last_cnt++;
         avail -= 3;
         if (idx == N - 1) begin
            running = 1'b0;
            done_m  = 1'b1;
            avail   = 0;
            t_done  = cyc + 1;
         end
         idx++;
      end
      if (start_v && idle) begin
         running = 1'b1;
         avail   = 0;
         popped  = 0;
         idx     = 0;
      end
      cyc++;
   endtask

   task automatic run_frame(input int m, input logic [31:0] w[W]);
      int guard;
      load_frame(w);
      mode = m;
      bp_cnt = 0; gap_cnt = 0; dut_pops = 0; last_cnt = 0; stall = 0;
      seen_valid = 1'b0; t_first_rd = -1; t_first_valid = -1; t_done = -1;
      t_start = cyc;
      step(1'b1);
      guard = 0;
      while ((running || done_m) && guard < 200) begin
         step((m == 3) ? ($urandom_range(15) == 0) : 1'b0);
         guard++;
      end
      chk("frame_timeout", 32'(guard >= 200), 32'd0);
      step(1'b0);
      chk("pops_per_frame", 32'(dut_pops), 32'(W));
      chk("fifo_left", 32'(fq.size()), 32'd0);
      chk("last_count", 32'(last_cnt), 32'd1);
   endtask

   task automatic chk_basic_pixels();
      chk("lit_pix0", 32'(got[0]), 32'h332211);
      chk("lit_pix1", 32'(got[1]), 32'h665544);
      chk("lit_pix2", 32'(got[2]), 32'h998877);
      chk("lit_pix3", 32'(got[3]), 32'hCCBBAA);
      chk("lit_pix6_pad", 32'(got[6]), 32'h997766);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
      chk({tag, "_valid"}, 32'(bus.pix_valid), 32'd0);
      chk({tag, "_data"}, 32'(bus.pix_data), 32'd0);
      chk({tag, "_last"}, 32'(bus.pix_last), 32'd0);
   endtask

   initial begin
      int guard;
      basic[0] = 32'h44332211;
      basic[1] = 32'h88776655;
      basic[2] = 32'hCCBBAA99;
      basic[3] = 32'h00FFEEDD;
      basic[4] = 32'h77665544;
      basic[5] = 32'hDEADBE99;   // only 0x99 is pixel data
      bus.start = 1'b0;
      bus.pix_ready = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_dout = 32'd0;
      mode = 0;
      running = 1'b0; done_m = 1'b0; avail = 0; popped = 0; idx = 0;
      #1;
      chk_outputs_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Full-rate gearbox with latency and throughput pins.
      run_frame(0, basic);
      chk_basic_pixels();
      chk("lat_first_rd", 32'(t_first_rd - t_start), 32'd1);
      chk("lat_first_valid", 32'(t_first_valid - t_start), 32'd2);
      chk("lat_done", 32'(t_done - t_start), 32'd9);
      chk("throughput_stalls", 32'(stall), 32'd0);

      // Backpressure on the second pixel.
      run_frame(1, basic);
      chk("bp_cycles", 32'(bp_cnt), 32'd5);
      chk_basic_pixels();

      // FIFO starvation after two words.
      run_frame(2, basic);
      chk("gap_cycles", 32'(gap_cnt), 32'd10);
      chk_basic_pixels();

      // Asynchronous reset mid-frame, then a fresh frame.
      load_frame(basic);
      mode = 0; dut_pops = 0; t_first_rd = -1; t_first_valid = -1;
      step(1'b1);
      guard = 0;
      while (idx < 2 && guard < 50) begin
         step(1'b0);
         guard++;
      end
      chk("reset_reach", 32'(idx), 32'd2);
      #2 reset = 1'b0;
      #1;
      chk_outputs_zero("abort");
      running = 1'b0; done_m = 1'b0; avail = 0; popped = 0; idx = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      run_frame(0, basic);
      chk_basic_pixels();

      // Random data, random ready/empty, stray starts.
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < W; i++) rnd[i] = $urandom;
         run_frame(3, rnd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bmp_word_unpacker.md
Name: bmp_word_unpacker

Overview:
- Reader-side counterpart of the 32-bit image FIFOs that the frame loader fills with raw BMP pixel bytes, packed little-endian four to a word.
- Pops words from one FIFO and re-slices the byte stream into 24-bit BGR pixels for the motion-detect datapath.
- One instance sits behind each of the background FIFO and the frame FIFO.
- Handles the 3-words-to-4-pixels gearbox, frame pixel counting, and discard of padding bytes in the final word.

Parameters:
- NUM_PIXELS, 388800: pixels per frame (720x540).
- FIFO_WIDTH, 32: FIFO word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a frame when idle.
- fifo_empty  in  1  source FIFO empty flag.
- fifo_dout  in  32  FIFO first-word-fall-through data; valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pops the current FIFO word at this rising edge.
- pix_data  out  24  pixel {R,G,B}; B = earliest byte, in [7:0].
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts the pixel when pix_valid & pix_ready.
- pix_last  out  1  high with the final pixel (index NUM_PIXELS-1).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Constants: WORDS = ceil(3*NUM_PIXELS/4). Word byte k is fifo_dout[8k+:8]; byte 0 is earliest in the stream.
- Storage: 48-bit byte buffer plus byte count cnt (0..6). A word counter (up to WORDS) and a pixel counter (up to NUM_PIXELS) run alongside.
- Reset (reset=0, asynchronous): state=IDLE; cnt and both counters cleared; every output 0.
- IDLE:
  - fifo_rd_en=0, pix_valid=0.
  - start=1 -> RUN; counters and cnt cleared.
  - FIFO contents are never touched while idle.
- RUN, pop rule (combinational):
  - emit = pix_valid & pix_ready.
  - fifo_rd_en = !fifo_empty & (words_popped < WORDS) & ((cnt - (emit?3:0)) <= 2).
- RUN, emit rule: pix_valid = (cnt >= 3). pix_data = the oldest 3 buffered bytes.
- Same-cycle pop and emit: cnt' = cnt - 3 + 4. The new word's bytes append after the surviving bytes; byte order is preserved.
- Throughput: with the FIFO never empty and pix_ready held at 1, the unit sustains 1 pixel/cycle after start-up.
- Latency: first fifo_rd_en is asserted the cycle after start. pix_valid rises the cycle after the first pop.
- Backpressure: while pix_valid=1 and pix_ready=0, pix_data and pix_last stay stable. fifo_rd_en only fires if cnt<=2.
- Empty FIFO: fifo_rd_en=0; the block stalls with no data loss. A pixel already buffered is still presented.
- pix_last: pix_valid & (pixel counter == NUM_PIXELS-1).
- Padding bytes: when 3*NUM_PIXELS mod 4 != 0, the final word is still popped (exactly WORDS pops per frame). Its leftover bytes are discarded.
- End of frame: last pixel handshake -> DONE; cnt is cleared.
- DONE: done=1 for exactly one cycle, outputs idle, then IDLE.
- start while in RUN or DONE is ignored.
- Reset mid-frame: immediate abort to the reset state. Partial buffer contents are lost. Words not yet popped remain in the FIFO; draining them is the system's responsibility.
- busy=1 exactly while in RUN.

Test Plan:
- Basic gearbox: NUM_PIXELS=4; FIFO words 0x44332211, 0x88776655, 0xCCBBAA99; start -> pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA. pix_last on the 4th pixel only; exactly 3 pops; done pulses 1 cycle later.
- Padding discard: NUM_PIXELS=3; words 0x44332211, 0x88776655, 0xDEAD0099 -> pixels 0x332211, 0x665544, 0x998877. Exactly 3 pops; 0xAD/0xDE never appear.
- Backpressure: pix_ready=0 for 5 cycles at the 2nd pixel -> pix_data holds 0x665544 stable, no extra pops (cnt<=6). Resuming gives the same sequence as the basic case.
- FIFO starvation: fifo_empty=1 for 10 cycles between words 1 and 2 -> no fifo_rd_en during the gap; output sequence identical; pix_valid low once the buffer drains below 3 bytes.
- Throughput: NUM_PIXELS=388800, FIFO always full, pix_ready=1 -> 291600 pops. Output matches a byte-wise BGR reference model of base.bmp; pix_valid continuous after the first pixel.
- Reset mid-frame: reset=0 after 2 pixels -> all outputs 0 asynchronously. A fresh start on a refilled FIFO reproduces the basic-case pixels from 0x332211.
